// File: rtl/memory_interface_if.sv
// memory_interface_if: NoC request/response channel plus memory bus strobes
//   master: core side (drives requests, resp_ready; observes everything else)
//   slave : memory_interface (accepts requests, returns responses, drives bus)
//   mem_dat is bidirectional and stays a plain inout port of the bridge.
interface memory_interface_if #(
    parameter int TAG_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [31:0]      req_addr;
    logic [127:0]     req_data;
    logic [TAG_W-1:0] req_tag;
    logic             resp_valid;
    logic             resp_ready;
    logic [127:0]     resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      mem_addr_sel;
    logic             mem_en;
    logic             mem_we;
    logic             mem_re;

    modport master (
        output req_valid, req_we, req_addr, req_data, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag,
               mem_addr_sel, mem_en, mem_we, mem_re
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_data, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag,
               mem_addr_sel, mem_en, mem_we, mem_re
    );
endinterface

// File: rtl/memory_interface.sv
// memory_interface: NoC request FIFO bridged to a fixed-length 128-bit memory bus
//   fclk    : fabric clock, rising edge
//   rst     : asynchronous active-low reset
//   bus     : memory_interface_if.slave (request/response channel, address, strobes)
//   mem_dat : bidirectional memory data, driven only while a write is on the bus
module memory_interface #(
    parameter int REQ_DEPTH  = 4,
    parameter int MEM_CYCLES = 3,
    parameter int TAG_W      = 4
) (
    input  logic                  fclk,
    input  logic                  rst,
    memory_interface_if.slave     bus,
    inout  wire  [127:0]          mem_dat
);
    localparam int PW = $clog2(REQ_DEPTH);
    localparam int CW = $clog2(MEM_CYCLES) + 1;

    typedef struct packed {
        logic             we;
        logic [31:0]      addr;
        logic [127:0]     data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    typedef enum logic [1:0] {IDLE, WRITE, READ, RESP} state_t;

    entry_t           r_mem [REQ_DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [PW:0]      r_cnt;
    logic             r_init;
    state_t           r_state;
    state_t           w_state_nx;
    logic [CW-1:0]    r_ctr;
    logic [127:0]     r_data;
    logic [TAG_W-1:0] r_tag;
    logic [31:0]      r_addr_sel;
    logic             r_resp_valid;
    logic [127:0]     r_resp_data;
    logic [TAG_W-1:0] r_resp_tag;
    logic             w_push;
    logic             w_pop;
    entry_t           w_head;

    assign w_head = r_mem[r_rp];
    // r_init keeps the channel closed until the first edge after reset release
    assign bus.req_ready    = r_init && (r_cnt != (PW+1)'(REQ_DEPTH));
    assign w_push           = bus.req_valid && bus.req_ready;
    assign bus.mem_en       = (r_state == WRITE) || (r_state == READ);
    assign bus.mem_we       = r_state == WRITE;
    assign bus.mem_re       = r_state == READ;
    assign bus.mem_addr_sel = r_addr_sel;
    assign bus.resp_valid   = r_resp_valid;
    assign bus.resp_data    = r_resp_data;
    assign bus.resp_tag     = r_resp_tag;
    assign mem_dat          = (r_state == WRITE) ? r_data : 'z;

    always_comb begin
        w_state_nx = r_state;
        w_pop      = 1'b0;
        case (r_state)
            IDLE: if (r_cnt != '0) begin
                w_pop      = 1'b1;
                w_state_nx = w_head.we ? WRITE : READ;
            end
            WRITE: if (r_ctr == '0) w_state_nx = IDLE;
            READ:  if (r_ctr == '0) w_state_nx = RESP;
            RESP:  if (bus.resp_ready) w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    // Storage carries no reset; occupancy and pointers define validity
    always_ff @(posedge fclk) begin
        if (w_push) r_mem[r_wp] <= '{bus.req_we, bus.req_addr, bus.req_data, bus.req_tag};
    end

    always_ff @(posedge fclk or negedge rst) begin
        if (!rst) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_init       <= 1'b0;
            r_state      <= IDLE;
            r_ctr        <= '0;
            r_data       <= '0;
            r_tag        <= '0;
            r_addr_sel   <= '0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= '0;
            r_resp_tag   <= '0;
        end else begin
            r_init  <= 1'b1;
            r_state <= w_state_nx;
            r_cnt   <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (w_push) r_wp <= r_wp + PW'(1);
            if (w_pop) begin
                r_rp       <= r_rp + PW'(1);
                r_ctr      <= CW'(MEM_CYCLES - 1);
                r_data     <= w_head.data;
                r_tag      <= w_head.tag;
                r_addr_sel <= w_head.addr & 32'hFFFF_FFF0;
            end else if (r_ctr != '0) begin
                r_ctr <= r_ctr - CW'(1);
            end
            if (r_state == READ && r_ctr == '0) begin
                r_resp_valid <= 1'b1;
                r_resp_data  <= mem_dat;
                r_resp_tag   <= r_tag;
            end else if (r_state == RESP && bus.resp_ready) begin
                r_resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_memory_interface.sv
// tb_memory_interface: directed checks of reset, write, read, backpressure, FIFO full, mid-read reset
module tb_memory_interface;
    localparam logic [127:0] WDATA = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
    localparam logic [127:0] RDATA = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
    localparam logic [127:0] RDAT2 = 128'h55AA55AA_00FF00FF_A5A5A5A5_0F0F0F0F;

    logic         fclk = 1'b0;
    logic         rst  = 1'b1;
    logic [127:0] mem_model = RDATA;
    wire  [127:0] mem_dat;
    int           n_chk = 0;
    int           n_pass = 0;
    int           n_fail = 0;
    logic [3:0]   got[$];

    always #5 fclk = ~fclk;

    memory_interface_if #(.TAG_W(4)) bus();

    // Memory model drives the data bus whenever the bridge is not writing;
    // any bridge drive outside a write therefore corrupts what is observed.
    assign mem_dat = bus.mem_we ? 'z : mem_model;

    memory_interface #(.REQ_DEPTH(4), .MEM_CYCLES(3), .TAG_W(4)) dut (
        .fclk(fclk), .rst(rst), .bus(bus), .mem_dat(mem_dat)
    );

    always @(posedge fclk) if (rst && bus.resp_valid && bus.resp_ready) got.push_back(bus.resp_tag);

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge fclk);
    endtask

    task automatic push(input logic we, input logic [31:0] a, input logic [127:0] d, input logic [3:0] t);
        int k = 0;
        bus.req_we = we; bus.req_addr = a; bus.req_data = d; bus.req_tag = t; bus.req_valid = 1'b1;
        while (!bus.req_ready && k < 100) begin tick(); k++; end
        check("push_accept", bus.req_ready, 1);
        tick();
        bus.req_valid = 1'b0;
    endtask

    initial begin
        int k;
        logic seen;
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_data = '0;
        bus.req_tag = '0; bus.resp_ready = 1'b1;
        #1 rst = 1'b0;
        tick(3);
        check("rst_req_ready", bus.req_ready, 0);
        check("rst_resp_valid", bus.resp_valid, 0);
        check("rst_strobes", {bus.mem_en, bus.mem_we, bus.mem_re}, 0);
        check("rst_addr", bus.mem_addr_sel, 0);
        check("rst_resp_data", bus.resp_data, 0);
        check("rst_resp_tag", bus.resp_tag, 0);
        check("rst_dat_released", mem_dat, mem_model);
        bus.req_valid = 1'b0;
        rst = 1'b1;
        #1 check("rel_ready_before_edge", bus.req_ready, 0);
        tick();
        check("rel_ready_after_edge", bus.req_ready, 1);

        push(1'b1, 32'h0000_1234, WDATA, 4'd2);
        check("wr_no_strobe_yet", bus.mem_en, 0);
        tick();
        check("wr_addr", bus.mem_addr_sel, 32'h0000_1230);
        check("wr_strobes_c1", {bus.mem_en, bus.mem_we, bus.mem_re}, 3'b110);
        check("wr_dat", mem_dat, WDATA);
        tick();
        check("wr_strobes_c2", {bus.mem_en, bus.mem_we}, 2'b11);
        tick();
        check("wr_strobes_c3", {bus.mem_en, bus.mem_we}, 2'b11);
        check("wr_dat_c3", mem_dat, WDATA);
        tick();
        check("wr_strobes_done", {bus.mem_en, bus.mem_we, bus.mem_re}, 0);
        check("wr_dat_released", mem_dat, mem_model);
        check("wr_no_resp", bus.resp_valid, 0);
        check("wr_addr_held", bus.mem_addr_sel, 32'h0000_1230);

        push(1'b0, 32'h0000_0040, '0, 4'd5);
        check("rd_no_strobe_yet", bus.mem_re, 0);
        tick();
        check("rd_strobes_c1", {bus.mem_en, bus.mem_we, bus.mem_re}, 3'b101);
        check("rd_addr", bus.mem_addr_sel, 32'h0000_0040);
        check("rd_dat_released", mem_dat, RDATA);
        tick(2);
        check("rd_strobes_c3", bus.mem_re, 1);
        check("rd_no_resp_yet", bus.resp_valid, 0);
        tick();
        check("rd_resp_valid", bus.resp_valid, 1);
        check("rd_resp_data", bus.resp_data, RDATA);
        check("rd_resp_tag", bus.resp_tag, 5);
        check("rd_strobes_done", bus.mem_en, 0);
        tick();
        check("rd_resp_cleared", bus.resp_valid, 0);

        bus.resp_ready = 1'b0;
        push(1'b0, 32'h0000_0080, '0, 4'd6);
        push(1'b0, 32'h0000_0090, '0, 4'd7);
        tick(3);
        check("bp_valid", bus.resp_valid, 1);
        check("bp_tag", bus.resp_tag, 6);
        mem_model = RDAT2;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_hold_data", bus.resp_data, RDATA);
            check("bp_hold_ctl", {bus.resp_valid, bus.mem_en, bus.resp_tag}, {1'b1, 1'b0, 4'd6});
        end
        bus.resp_ready = 1'b1;
        tick();
        check("bp_release", {bus.resp_valid, bus.mem_en}, 0);
        tick();
        check("bp_next_start", bus.mem_re, 1);
        check("bp_next_addr", bus.mem_addr_sel, 32'h0000_0090);
        tick(3);
        check("bp_next_resp", {bus.resp_valid, bus.resp_tag}, {1'b1, 4'd7});
        check("bp_next_data", bus.resp_data, RDAT2);
        tick();

        got.delete();
        bus.resp_ready = 1'b0;
        push(1'b0, 32'h0000_0100, '0, 4'd8);
        push(1'b0, 32'h0000_0110, '0, 4'd9);
        push(1'b1, 32'h0000_0120, WDATA, 4'd10);
        push(1'b0, 32'h0000_0130, '0, 4'd11);
        push(1'b0, 32'h0000_0140, '0, 4'd12);
        check("full_ready_low", bus.req_ready, 0);
        check("full_head_resp", {bus.resp_valid, bus.resp_tag}, {1'b1, 4'd8});
        tick();
        check("full_ready_still_low", bus.req_ready, 0);
        bus.resp_ready = 1'b1;
        push(1'b0, 32'h0000_0150, '0, 4'd13);
        k = 0;
        while (got.size() < 5 && k < 200) begin tick(); k++; end
        check("order_count", got.size(), 5);
        if (got.size() == 5) begin
            check("order_0", got[0], 8);
            check("order_1", got[1], 9);
            check("order_2", got[2], 11);
            check("order_3", got[3], 12);
            check("order_4", got[4], 13);
        end
        tick();

        got.delete();
        push(1'b0, 32'h0000_0200, '0, 4'd14);
        push(1'b0, 32'h0000_0210, '0, 4'd15);
        check("mid_in_read", bus.mem_re, 1);
        tick();
        rst = 1'b0;
        #1;
        check("mid_strobes_drop", {bus.mem_en, bus.mem_we, bus.mem_re}, 0);
        check("mid_no_resp", bus.resp_valid, 0);
        check("mid_ready_low", bus.req_ready, 0);
        tick(2);
        rst = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen = seen | bus.mem_en | bus.resp_valid;
        end
        check("mid_fifo_empty", seen, 0);
        check("mid_no_handshake", got.size(), 0);
        check("mid_ready_back", bus.req_ready, 1);
        push(1'b0, 32'h0000_0300, '0, 4'd3);
        k = 0;
        while (!bus.resp_valid && k < 50) begin tick(); k++; end
        check("post_rst_resp_tag", {bus.resp_valid, bus.resp_tag}, {1'b1, 4'd3});
        tick();
        check("post_rst_only_one", got.size(), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/memory_interface.md
Name: memory_interface

Overview:
- Bridges the core's NoC request channel to the external 128-bit SoC memory bus; returns read data to the core as NoC response packets.
- Sits in soc between the core and the off-chip memory pins.
- Buffers requests in a small FIFO and serves them one at a time, in order, with fixed-length memory bus cycles.

Parameters:
- REQ_DEPTH, 4, request FIFO depth (power of 2, ≥2).
- MEM_CYCLES, 3, clock cycles each memory access is held on the bus (one mclk period = 3 fclk).
- TAG_W, 4, width of the request/response tag.

Ports:
- fclk  in  1  fabric clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  NoC request present.
- req_ready  out  1  request accepted when req_valid && req_ready; high iff FIFO not full.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_data  in  128  write data.
- req_tag  in  TAG_W  transaction tag, echoed on response.
- resp_valid  out  1  read response present.
- resp_ready  in  1  core accepts response.
- resp_data  out  128  read data.
- resp_tag  out  TAG_W  tag of the originating read.
- mem_addr_sel  out  32  line address = {addr[31:4],4'b0}.
- mem_dat  inout  128  bidirectional memory data.
- mem_en  out  1  memory access active.
- mem_we  out  1  write strobe.
- mem_re  out  1  read strobe.

Behaviour:
- Reset (rst=0, async):
  - FIFO empty; state IDLE; counter 0.
  - req_ready=0 while rst is low; req_ready=1 from the first edge after release.
  - resp_valid=0; resp_data=0; resp_tag=0.
  - mem_en/mem_we/mem_re=0; mem_addr_sel=0; mem_dat tri-stated.
  - Reset mid-operation aborts the access immediately; no response is issued.
- FIFO:
  - Stores {we, addr, data, tag}.
  - Push on req_valid && req_ready.
  - Pop when IDLE dispatches an entry.
  - Simultaneous push and pop when full is not allowed; req_ready is based on registered full.
  - Pointers wrap modulo REQ_DEPTH.
- State machine:
  - IDLE: if FIFO non-empty, pop the head, latch fields, load counter with MEM_CYCLES-1, go to WRITE or READ. mem_addr_sel and strobes are registered, so the bus changes on the edge leaving IDLE.
  - WRITE: mem_en=1, mem_we=1, mem_re=0; mem_dat driven with latched data. Decrement counter; at 0, go to IDLE with strobes cleared and mem_dat released the same edge. Writes produce no response.
  - READ: mem_en=1, mem_re=1, mem_we=0; mem_dat tri-stated. At counter 0, capture mem_dat into resp_data, set resp_valid=1 with the latched tag, go to RESP.
  - RESP: bus idle (all strobes 0). Hold resp_valid, resp_data and resp_tag stable until resp_ready=1. On handshake, clear resp_valid and go to IDLE.
- Read latency:
  - Request accepted with empty FIFO and IDLE: strobes rise 2 edges later (push, then dispatch).
  - resp_valid rises MEM_CYCLES edges after the strobes rise.
- Ordering: strictly FIFO; one access in flight. mem_dat is driven only in WRITE, never in any other state.
- mem_addr_sel holds the last address after an access completes; only the strobes return to 0.

Test Plan:
- Reset: hold rst=0 for 3 cycles with req_valid=1 → req_ready=0, resp_valid=0, all strobes 0, mem_dat=Z. After release, req_ready=1 on the next edge.
- Write: we=1, addr=0x0000_1234, data=0xDEADBEEF…(128b), tag=2 → mem_addr_sel=0x0000_1230; mem_en=mem_we=1 for exactly 3 cycles with mem_dat=data; no resp_valid.
- Read: model returns 0x0123…CDEF; request addr=0x40, tag=5 → mem_re=1 for 3 cycles, mem_dat=Z; resp_valid=1, resp_data=model value, resp_tag=5; strobes rise 2 edges after acceptance.
- Backpressure: hold resp_ready=0 for 10 cycles → resp stays valid and stable, no new bus access. resp_ready=1 → next queued request starts 2 edges later.
- FIFO full: enqueue 5 requests back-to-back during a read → req_ready=0 after 4 are queued. All complete in order; tags return in order for the reads.
- Reset mid-read: assert rst during READ cycle 2 → strobes drop immediately, no response, FIFO empty after release.
